mul_div_unit: RTL and testbench



---
 rtl/mdu_pkg.sv | 28 ++
 rtl/mdu_arith.sv | 56 +++++
 rtl/mul_div_unit.sv | 136 +++++++++++++
 tb/tb_mul_div_unit.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op codes, HI/LO read selects, FSM states.
package mdu_pkg;

   typedef enum logic [3:0] {
      OP_NOP   = 4'd0,
      OP_MULT  = 4'd1,
      OP_MULTU = 4'd2,
      OP_DIV   = 4'd3,
      OP_DIVU  = 4'd4,
      OP_MTHI  = 4'd5,
      OP_MTLO  = 4'd6,
      OP_MADD  = 4'd7,
      OP_MADDU = 4'd8
   } mdu_op_e;

   typedef enum logic [1:0] {
      RD_NONE  = 2'd0,
      RD_HI    = 2'd1,
      RD_LO    = 2'd2,
      RD_NONE3 = 2'd3
   } mdu_rd_sel_e;

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_RUN  = 1'b1
   } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit result generator for MULT/MULTU/DIV/DIVU/MADD/MADDU.
// Result layout is {hi, lo}; div_by_zero flags a zero divisor.
import mdu_pkg::*;

module mdu_arith (
   input  logic [3:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   input  logic [63:0] acc,
   output logic [63:0] res,
   output logic        div_by_zero
);

   logic [63:0] prod_s;
   logic [63:0] prod_u;
   logic [31:0] b_nz;
   logic [31:0] a_mag;
   logic [31:0] b_mag;
   logic [31:0] uq;
   logic [31:0] ur;
   logic [31:0] sq_mag;
   logic [31:0] sr_mag;
   logic [31:0] sq;
   logic [31:0] sr;

   always_comb begin
      prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
      prod_u = {32'd0, a} * {32'd0, b};

      // Zero divisor is replaced by 1 so the dividers stay defined; the result is discarded anyway.
      div_by_zero = (b == '0);
      b_nz        = div_by_zero ? 32'd1 : b;
      uq          = a / b_nz;
      ur          = a % b_nz;

      // Signed divide on magnitudes so 0x80000000 / -1 wraps to 0x80000000 instead of overflowing.
      a_mag  = a[31] ? (32'd0 - a) : a;
      b_mag  = b_nz[31] ? (32'd0 - b_nz) : b_nz;
      sq_mag = a_mag / b_mag;
      sr_mag = a_mag % b_mag;
      sq     = (a[31] ^ b_nz[31]) ? (32'd0 - sq_mag) : sq_mag;
      sr     = a[31] ? (32'd0 - sr_mag) : sr_mag;

      res = '0;
      case (op)
         OP_MULT:  res = prod_s;
         OP_MULTU: res = prod_u;
         OP_DIV:   res = {sr, sq};
         OP_DIVU:  res = {ur, uq};
         OP_MADD:  res = acc + prod_s;
         OP_MADDU: res = acc + prod_u;
         default:  res = '0;
      endcase
   end

endmodule

// File: rtl/mul_div_unit.sv
// E-stage multi-cycle multiply/divide unit owning HI/LO; busy covers the whole latency.
// Define MDU_MADD_EN to enable MADD/MADDU (otherwise those codes behave as NOP).
import mdu_pkg::*;

module mul_div_unit #(
   parameter int unsigned MULT_CYCLES = 5,
   parameter int unsigned DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic [3:0]  op,
   input  logic [31:0] src_a,
   input  logic [31:0] src_b,
   input  logic [1:0]  rd_sel,
   output logic        busy,
   output logic [31:0] result,
   output logic [31:0] hi,
   output logic [31:0] lo
);

`ifdef MDU_MADD_EN
   localparam bit MADD_EN = 1'b1;
`else
   localparam bit MADD_EN = 1'b0;
`endif

   localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);
   localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES - 1);

   mdu_state_e  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] pend_hi_q, pend_hi_d;
   logic [31:0] pend_lo_q, pend_lo_d;
   logic        pend_dz_q, pend_dz_d;
   logic [31:0] hi_q, hi_d;
   logic [31:0] lo_q, lo_d;
   logic        busy_q, busy_d;

   logic [63:0] arith_res;
   logic        div_by_zero;
   logic        is_mult;
   logic        is_div;

   mdu_arith u_arith (
      .op          (op),
      .a           (src_a),
      .b           (src_b),
      .acc         ({hi_q, lo_q}),
      .res         (arith_res),
      .div_by_zero (div_by_zero)
   );

   always_comb begin
      is_mult = (op == OP_MULT) || (op == OP_MULTU) ||
                (MADD_EN && ((op == OP_MADD) || (op == OP_MADDU)));
      is_div  = (op == OP_DIV) || (op == OP_DIVU);

      state_d   = state_q;
      cnt_d     = cnt_q;
      pend_hi_d = pend_hi_q;
      pend_lo_d = pend_lo_q;
      pend_dz_d = pend_dz_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      busy_d    = busy_q;

      unique case (state_q)
         ST_IDLE: begin
            if (start) begin
               if (is_mult || is_div) begin
                  state_d   = ST_RUN;
                  busy_d    = 1'b1;
                  cnt_d     = is_div ? DIV_LOAD : MULT_LOAD;
                  pend_hi_d = arith_res[63:32];
                  pend_lo_d = arith_res[31:0];
                  pend_dz_d = is_div && div_by_zero;
               end else if (op == OP_MTHI) begin
                  hi_d = src_a;
               end else if (op == OP_MTLO) begin
                  lo_d = src_a;
               end
            end
         end
         ST_RUN: begin
            // New starts are deliberately not looked at here.
            if (cnt_q == '0) begin
               state_d = ST_IDLE;
               busy_d  = 1'b0;
               if (!pend_dz_q) begin
                  hi_d = pend_hi_q;
                  lo_d = pend_lo_q;
               end
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         cnt_q     <= '0;
         pend_hi_q <= '0;
         pend_lo_q <= '0;
         pend_dz_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pend_hi_q <= pend_hi_d;
         pend_lo_q <= pend_lo_d;
         pend_dz_q <= pend_dz_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      case (rd_sel)
         RD_HI:   result = hi_q;
         RD_LO:   result = lo_q;
         default: result = '0;
      endcase
   end

   assign busy = busy_q;
   assign hi   = hi_q;
   assign lo   = lo_q;

endmodule

// File: tb/tb_mul_div_unit.sv
// Self-checking bench for mul_div_unit: directed cases plus random ops against an arithmetic model.
module tb_mul_div_unit;

   localparam int MC = 5;
   localparam int DC = 10;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic [3:0]  op;
   logic [31:0] src_a;
   logic [31:0] src_b;
   logic [1:0]  rd_sel;
   logic        busy;
   logic [31:0] result;
   logic [31:0] hi;
   logic [31:0] lo;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_hi = '0;
   logic [31:0] m_lo = '0;

   mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .src_a  (src_a),
      .src_b  (src_b),
      .rd_sel (rd_sel),
      .busy   (busy),
      .result (result),
      .hi     (hi),
      .lo     (lo)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   // Architectural model: updates m_hi/m_lo and returns expected busy length.
   task automatic model_op(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                           output int n);
      longint          sa, sb, sp;
      longint unsigned ua, ub, up;
      logic [63:0]     acc;
      sa  = longint'($signed(a));
      sb  = longint'($signed(b));
      ua  = longint'(a);
      ub  = longint'(b);
      acc = {m_hi, m_lo};
      n   = 0;
      case (o)
         4'd1: begin sp = sa * sb; {m_hi, m_lo} = sp; n = MC; end
         4'd2: begin up = ua * ub; {m_hi, m_lo} = up; n = MC; end
         4'd3: begin
            n = DC;
            if (b != 0) begin m_lo = 32'(sa / sb); m_hi = 32'(sa % sb); end
         end
         4'd4: begin
            n = DC;
            if (b != 0) begin m_lo = 32'(ua / ub); m_hi = 32'(ua % ub); end
         end
         4'd5: m_hi = a;
         4'd6: m_lo = a;
`ifdef MDU_MADD_EN
         4'd7: begin sp = sa * sb; {m_hi, m_lo} = acc + 64'(sp); n = MC; end
         4'd8: begin up = ua * ub; {m_hi, m_lo} = acc + up; n = MC; end
`endif
         default: n = 0;
      endcase
   endtask

   task automatic check_state(input string tag);
      chk({tag, "_hi"}, hi, m_hi);
      chk({tag, "_lo"}, lo, m_lo);
      for (int s = 0; s < 4; s++) begin
         rd_sel = 2'(s);
         #1;
         chk({tag, "_result"}, result, (s == 1) ? m_hi : (s == 2) ? m_lo : 32'd0);
      end
   endtask

   // Issues one op, measures the busy-high length, then checks HI/LO and result.
   task automatic run_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                         input logic [31:0] b);
      int n;
      int cyc;
      model_op(o, a, b, n);
      @(negedge clk);
      start = 1'b1; op = o; src_a = a; src_b = b;
      @(posedge clk); #1;
      start = 1'b0; op = 4'd0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         @(posedge clk); #1;
      end
      chk({tag, "_busy_cycles"}, 32'(cyc), 32'(n));
      check_state(tag);
   endtask

   initial begin
      int cyc;
      int n;
      logic [3:0]  ro;
      logic [31:0] ra, rb;

      reset = 1'b1; start = 1'b0; op = '0; src_a = '0; src_b = '0; rd_sel = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset_busy", 32'(busy), 32'd0);
      check_state("reset");
      @(negedge clk) reset = 1'b0;

      run_op("mult_neg", 4'd1, 32'hFFFF_FFFE, 32'd3);
      chk("mult_neg_hi_const", hi, 32'hFFFF_FFFF);
      chk("mult_neg_lo_const", lo, 32'hFFFF_FFFA);
      run_op("multu_max", 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
      chk("multu_hi_const", hi, 32'hFFFF_FFFE);
      chk("multu_lo_const", lo, 32'h0000_0001);
      run_op("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2);
      chk("div_neg_lo_const", lo, 32'hFFFF_FFFD);
      chk("div_neg_hi_const", hi, 32'hFFFF_FFFF);
      run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("div_ovf_lo_const", lo, 32'h8000_0000);
      chk("div_ovf_hi_const", hi, 32'h0000_0000);
      run_op("pre_dz", 4'd5, 32'h1357_9BDF, 32'd0);
      run_op("divu_zero", 4'd4, 32'd7, 32'd0);
      chk("divu_zero_hi_kept", hi, 32'h1357_9BDF);

      // MTHI then MTLO on back-to-back cycles; busy must never rise.
      m_hi = 32'h1234_5678; m_lo = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b1; op = 4'd5; src_a = 32'h1234_5678;
      @(negedge clk);
      chk("mthi_busy", 32'(busy), 32'd0);
      op = 4'd6; src_a = 32'h9ABC_DEF0;
      @(negedge clk);
      start = 1'b0; op = 4'd0;
      chk("mtlo_busy", 32'(busy), 32'd0);
      @(negedge clk);
      chk("mt_busy_after", 32'(busy), 32'd0);
      check_state("mt_pair");

      // DIV with a MULT start injected during RUN; the MULT must be ignored.
      model_op(4'd3, 32'd100, 32'd7, n);
      @(negedge clk);
      start = 1'b1; op = 4'd3; src_a = 32'd100; src_b = 32'd7;
      @(posedge clk); #1;
      start = 1'b0; op = 4'd0;
      cyc = 0;
      while (busy === 1'b1 && cyc < 40) begin
         cyc++;
         if (cyc == 3) begin
            @(negedge clk);
            start = 1'b1; op = 4'd1; src_a = 32'd9; src_b = 32'd9;
         end
         @(posedge clk); #1;
         start = 1'b0; op = 4'd0;
      end
      chk("div_ignore_busy_cycles", 32'(cyc), 32'(n));
      check_state("div_ignore");

      // MADDU accumulate, or NOP behaviour when the feature is compiled out.
      run_op("madd_pre_hi", 4'd5, 32'd0, 32'd0);
      run_op("madd_pre_lo", 4'd6, 32'hFFFF_FFFF, 32'd0);
      run_op("maddu", 4'd8, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
      chk("maddu_hi_const", hi, 32'd1);
      chk("maddu_lo_const", lo, 32'd0);
`else
      chk("maddu_off_hi_const", hi, 32'd0);
      chk("maddu_off_lo_const", lo, 32'hFFFF_FFFF);
`endif
      run_op("madd_signed", 4'd7, 32'hFFFF_FFFD, 32'd4);

      for (int i = 0; i < 30; i++) begin
         ro = 4'($urandom_range(0, 15));
         ra = $urandom;
         rb = ($urandom_range(0, 7) == 0) ? 32'd0 :
              ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
         if ($urandom_range(0, 3) == 0) ra = {{24{ra[31]}}, ra[7:0]};
         run_op($sformatf("rand%0d_op%0d", i, ro), ro, ra, rb);
      end

      // Asynchronous reset in the middle of a DIV.
      run_op("pre_reset", 4'd5, 32'hA5A5_A5A5, 32'd0);
      @(negedge clk);
      start = 1'b1; op = 4'd3; src_a = 32'd1000; src_b = 32'd3;
      @(posedge clk); #1;
      start = 1'b0; op = 4'd0;
      chk("pre_reset_busy", 32'(busy), 32'd1);
      repeat (3) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      m_hi = '0; m_lo = '0;
      chk("async_reset_busy", 32'(busy), 32'd0);
      chk("async_reset_hi", hi, 32'd0);
      chk("async_reset_lo", lo, 32'd0);
      @(negedge clk) reset = 1'b0;
      repeat (15) @(posedge clk);
      #1;
      chk("post_reset_busy", 32'(busy), 32'd0);
      check_state("post_reset");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
